// File: rtl/upload_req_fifo.sv
// upload_req_fifo: outgoing request-flit buffer between the upload stage and
// the ring injection port. Flits are buffered as {ctrl, flit} and released
// packet by packet: the head of the queue is only offered once at least one
// complete packet (through its tail) is held, so the ring never stalls mid-packet.
module upload_req_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v_flit_in,
  input  logic [15:0]   flit_in,
  input  logic [1:0]    ctrl_in,
  output logic          out_req_fifo_rdy,
  output logic          v_flit_out,
  output logic [15:0]   flit_out,
  output logic [1:0]    ctrl_out,
  input  logic          flit_ack_in,
  output logic [AW:0]   fifo_count,
  output logic [AW:0]   pkt_count,
  output logic          err_overflow
);

  localparam logic [1:0]    CTRL_TAIL = 2'b11;
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  logic [17:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fifo_count;
  logic [AW:0]   r_pkt_count;
  logic          r_err_overflow;

  logic [17:0]   w_head;
  logic          w_wr;
  logic          w_pop;
  logic          w_wr_tail;
  logic          w_pop_tail;

  // Readiness comes only from the registered count, so a full FIFO refuses a
  // write even in a cycle where the ring side pops.
  assign out_req_fifo_rdy = (r_fifo_count != CNT_FULL);
  assign v_flit_out       = (r_pkt_count != '0);

  assign w_head     = r_mem[r_rd_ptr];
  assign w_wr       = v_flit_in & out_req_fifo_rdy;
  assign w_pop      = v_flit_out & flit_ack_in;
  assign w_wr_tail  = w_wr & (ctrl_in == CTRL_TAIL);
  assign w_pop_tail = w_pop & (w_head[17:16] == CTRL_TAIL);

  // Outputs are gated to zero whenever nothing is being offered.
  assign flit_out     = v_flit_out ? w_head[15:0]  : 16'h0000;
  assign ctrl_out     = v_flit_out ? w_head[17:16] : 2'b00;
  assign fifo_count   = r_fifo_count;
  assign pkt_count    = r_pkt_count;
  assign err_overflow = r_err_overflow;

  // Flit storage; deliberately not reset, contents are only seen through the gated outputs.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {ctrl_in, flit_in};
    end
  end

  // Pointers, occupancy and packet counters; simultaneous inc/dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_pkt_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_ONE;
        2'b01:   r_fifo_count <= r_fifo_count - CNT_ONE;
        default: r_fifo_count <= r_fifo_count;
      endcase
      case ({w_wr_tail, w_pop_tail})
        2'b10:   r_pkt_count <= r_pkt_count + CNT_ONE;
        2'b01:   r_pkt_count <= r_pkt_count - CNT_ONE;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Sticky overflow flag: a write into a full FIFO is dropped and remembered until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_overflow <= 1'b0;
    end else if (v_flit_in & ~out_req_fifo_rdy) begin
      r_err_overflow <= 1'b1;
    end
  end

  // Structural invariants of the counters and pointers.
  a_count_order : assert property (@(posedge clk) disable iff (rst)
    (r_pkt_count <= r_fifo_count) && (r_fifo_count <= CNT_FULL));

  a_ptr_distance : assert property (@(posedge clk) disable iff (rst)
    (r_fifo_count == CNT_FULL) || (r_fifo_count[AW-1:0] == AW'(r_wr_ptr - r_rd_ptr)));

  a_no_empty_pop : assert property (@(posedge clk) disable iff (rst)
    w_pop |-> (r_pkt_count != '0));

endmodule

// File: tb/tb_upload_req_fifo.sv
// Testbench for upload_req_fifo: directed scenarios plus randomized packet
// traffic, all checked every cycle against a queue-based model of the buffer.
module tb_upload_req_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk;
  logic        rst;
  logic        vFlitIn;
  logic [15:0] flitIn;
  logic [1:0]  ctrlIn;
  logic        flitAckIn;
  logic        rdy;
  logic        vFlitOut;
  logic [15:0] flitOut;
  logic [1:0]  ctrlOut;
  logic [AW:0] fifoCount;
  logic [AW:0] pktCount;
  logic        errOverflow;

  int nChecks = 0;
  int nFail   = 0;

  // Model state: the buffered {ctrl, flit} entries in order, plus the sticky error.
  logic [17:0] mq[$];
  bit          mErr;

  upload_req_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .v_flit_in        (vFlitIn),
    .flit_in          (flitIn),
    .ctrl_in          (ctrlIn),
    .out_req_fifo_rdy (rdy),
    .v_flit_out       (vFlitOut),
    .flit_out         (flitOut),
    .ctrl_out         (ctrlOut),
    .flit_ack_in      (flitAckIn),
    .fifo_count       (fifoCount),
    .pkt_count        (pktCount),
    .err_overflow     (errOverflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int modelTails();
    int n = 0;
    foreach (mq[i]) if (mq[i][17:16] == 2'b11) n++;
    return n;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model says it must be now.
  task automatic checkOutput();
    int tails = modelTails();
    bit expV = (tails > 0);
    checkVal("rdy", int'(rdy), int'(mq.size() != DEPTH));
    checkVal("v_flit_out", int'(vFlitOut), int'(expV));
    checkVal("flit_out", int'(flitOut), expV ? int'(mq[0][15:0]) : 0);
    checkVal("ctrl_out", int'(ctrlOut), expV ? int'(mq[0][17:16]) : 0);
    checkVal("fifo_count", int'(fifoCount), mq.size());
    checkVal("pkt_count", int'(pktCount), tails);
    checkVal("err_overflow", int'(errOverflow), int'(mErr));
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then check.
  task automatic applyStimulus(input bit v, input logic [15:0] f, input logic [1:0] c, input bit a);
    bit accept;
    bit pop;
    vFlitIn   = v;
    flitIn    = f;
    ctrlIn    = c;
    flitAckIn = a;
    accept = v && (mq.size() != DEPTH);
    pop    = a && (modelTails() > 0);
    if (v && !accept) mErr = 1'b1;
    if (pop) void'(mq.pop_front());
    if (accept) mq.push_back({c, f});
    @(negedge clk);
    checkOutput();
  endtask

  // Ack until the model is empty, bounded so a stuck DUT cannot hang the run.
  task automatic drainAll();
    for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    checkVal("drain_empty", int'(fifoCount), 0);
  endtask

  initial begin
    logic [15:0] expFlits [6];
    logic [1:0]  expCtrls [6];
    int pktLen;
    int pktPos;
    bit accept;
    logic [1:0] c;

    expFlits = '{16'h1234, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h00FF};
    expCtrls = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};

    rst = 1'b1; vFlitIn = 1'b0; flitIn = '0; ctrlIn = '0; flitAckIn = 1'b0;
    mErr = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset state
    checkVal("rst_rdy", int'(rdy), 1);
    checkVal("rst_v", int'(vFlitOut), 0);
    checkVal("rst_fifo_count", int'(fifoCount), 0);
    checkVal("rst_pkt_count", int'(pktCount), 0);
    checkVal("rst_flit_out", int'(flitOut), 0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 2'b00, 1'b0);

    // 2: six-flit packet, nothing offered until the tail is in
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, expFlits[i], expCtrls[i], 1'b0);
      if (i < 5) checkVal("partial_v", int'(vFlitOut), 0);
    end
    checkVal("s2_v", int'(vFlitOut), 1);
    checkVal("s2_head", int'(flitOut), 16'h1234);
    checkVal("s2_ctrl", int'(ctrlOut), 1);
    checkVal("s2_fifo_count", int'(fifoCount), 6);
    checkVal("s2_pkt_count", int'(pktCount), 1);

    // 3: continuous ack drains the packet in order
    for (int i = 0; i < 6; i++) begin
      checkVal("s3_flit", int'(flitOut), int'(expFlits[i]));
      checkVal("s3_ctrl", int'(ctrlOut), int'(expCtrls[i]));
      checkVal("s3_v", int'(vFlitOut), 1);
      applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    end
    checkVal("s3_v_after", int'(vFlitOut), 0);
    checkVal("s3_fifo_count", int'(fifoCount), 0);
    checkVal("s3_pkt_count", int'(pktCount), 0);

    // 4: fill with 16 single-flit packets, overflow, then free one entry
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'hA000 + 16'(i), 2'b11, 1'b0);
    checkVal("s4_rdy_full", int'(rdy), 0);
    checkVal("s4_fifo_full", int'(fifoCount), 16);
    applyStimulus(1'b1, 16'hDEAD, 2'b11, 1'b0);
    checkVal("s4_err", int'(errOverflow), 1);
    checkVal("s4_fifo_after_ovf", int'(fifoCount), 16);
    checkVal("s4_head", int'(flitOut), 16'hA000);
    applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    checkVal("s4_rdy_freed", int'(rdy), 1);
    checkVal("s4_fifo_freed", int'(fifoCount), 15);
    drainAll();

    // 5: move pointers to entry 15, then concurrent tail write and tail pop across the wrap
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'hB000 + 16'(i), 2'b11, 1'b0);
    drainAll();
    applyStimulus(1'b1, 16'h0C01, 2'b11, 1'b0);
    applyStimulus(1'b1, 16'h0C10, 2'b01, 1'b0);
    applyStimulus(1'b1, 16'h0C11, 2'b10, 1'b0);
    applyStimulus(1'b1, 16'h0C12, 2'b11, 1'b0);
    applyStimulus(1'b1, 16'h0C20, 2'b01, 1'b0);
    checkVal("s5_fifo_pre", int'(fifoCount), 5);
    checkVal("s5_pkt_pre", int'(pktCount), 2);
    applyStimulus(1'b1, 16'h0C21, 2'b11, 1'b1);
    checkVal("s5_fifo_post", int'(fifoCount), 5);
    checkVal("s5_pkt_post", int'(pktCount), 2);
    checkVal("s5_head_post", int'(flitOut), 16'h0C10);
    drainAll();

    // Randomized packet traffic with occasional stored ctrl=00 body flits
    pktLen = 0;
    pktPos = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pktPos == pktLen) begin
        pktLen = $urandom_range(1, 6);
        pktPos = 0;
      end
      if (pktLen == 1) c = 2'b11;
      else if (pktPos == 0) c = 2'b01;
      else if (pktPos == pktLen - 1) c = 2'b11;
      else c = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b10;
      accept = ($urandom_range(0, 9) < 7);
      if (accept && mq.size() != DEPTH) pktPos++;
      applyStimulus(accept, 16'($urandom), c, ($urandom_range(0, 9) < 5));
    end
    // Close any half-written packet so the drain can finish
    while (pktPos != pktLen) begin
      c = (pktPos == pktLen - 1) ? 2'b11 : 2'b10;
      if (mq.size() != DEPTH) pktPos++;
      applyStimulus(1'b1, 16'($urandom), c, 1'b1);
    end
    drainAll();

    // 6: reset in the middle of draining a packet
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, expFlits[i], expCtrls[i], 1'b0);
    applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    checkVal("s6_mid_head", int'(flitOut), 16'h0002);
    rst = 1'b1;
    #1;
    mq.delete();
    mErr = 1'b0;
    checkVal("s6_rst_v", int'(vFlitOut), 0);
    checkVal("s6_rst_rdy", int'(rdy), 1);
    checkVal("s6_rst_fifo", int'(fifoCount), 0);
    checkVal("s6_rst_pkt", int'(pktCount), 0);
    checkVal("s6_rst_err", int'(errOverflow), 0);
    checkVal("s6_rst_flit", int'(flitOut), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 16'h5A01, 2'b01, 1'b0);
    applyStimulus(1'b1, 16'h5A02, 2'b10, 1'b0);
    applyStimulus(1'b1, 16'h5A03, 2'b11, 1'b0);
    checkVal("s6_new_head", int'(flitOut), 16'h5A01);
    checkVal("s6_new_fifo", int'(fifoCount), 3);
    applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    checkVal("s6_new_tail", int'(flitOut), 16'h5A03);
    checkVal("s6_new_tail_ctrl", int'(ctrlOut), 3);
    applyStimulus(1'b0, 16'h0, 2'b00, 1'b1);
    checkVal("s6_new_empty_v", int'(vFlitOut), 0);
    checkVal("s6_new_empty_fifo", int'(fifoCount), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/upload_req_fifo.md
Name: upload_req_fifo

Overview:
Outgoing request-flit buffer placed directly downstream of the upload FSM/datapath stage.
- Accepts {ctrl, flit} pairs written under v_flit_in.
- Returns out_req_fifo_rdy back to the upload FSM as its flow-control input.
- Presents flits to the ring-network injection port packet by packet: a flit is offered only once its whole packet (through its tail flit) is buffered, so the ring never sees a stalled partial packet.

Parameters:
DEPTH, 16, number of flit entries; power of two, >= 2; must be >= longest packet length.
AW, 4, pointer width = log2(DEPTH).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
v_flit_in  input  1  write strobe from upload stage (its v_flit_to_req_fifo).
flit_in  input  16  flit payload from upload stage.
ctrl_in  input  2  flit type: 01 head, 10 body, 11 tail/last; 00 is illegal.
out_req_fifo_rdy  output  1  free entry available; feeds upload FSM out_req_fifo_rdy_in.
v_flit_out  output  1  flit_out/ctrl_out valid toward ring injection.
flit_out  output  16  flit at FIFO head.
ctrl_out  output  2  ctrl at FIFO head.
flit_ack_in  input  1  ring side accepts current head flit this cycle.
fifo_count  output  AW+1  number of entries held, 0..DEPTH.
pkt_count  output  AW+1  number of complete packets (tails) held.
err_overflow  output  1  sticky: write attempted while full.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, fifo_count=0, pkt_count=0, err_overflow=0.
  - Outputs during and after reset: out_req_fifo_rdy=1, v_flit_out=0, flit_out/ctrl_out = 0 (memory contents are don't-care, but outputs are gated to 0 while v_flit_out=0).
  - Reset mid-packet discards all contents, including partial packets.
- Storage: DEPTH x 18 bits, {ctrl, flit}; memory itself is not reset.
- out_req_fifo_rdy = (fifo_count != DEPTH).
  - Combinational from registered count only; never depends on flit_ack_in.
  - A full FIFO therefore refuses a write even in a cycle where it pops.
- Write: when v_flit_in & out_req_fifo_rdy, store at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Overflow: when v_flit_in & !out_req_fifo_rdy, the flit is dropped, state is unchanged, and err_overflow is set to 1 until reset.
- Read side is first-word-fall-through:
  - flit_out/ctrl_out = mem[rd_ptr] when v_flit_out=1, else 0.
  - v_flit_out = (pkt_count != 0).
- Pop: when v_flit_out & flit_ack_in, rd_ptr increments (wraps); the next entry appears the following cycle. flit_ack_in while v_flit_out=0 is ignored.
- Latency: a packet's head flit appears on v_flit_out in the cycle after its tail is written, when the FIFO was empty before that packet.
- fifo_count update:
  - +1 on write only, -1 on pop only.
  - Unchanged on simultaneous write and pop, including at count DEPTH-1 with a pop.
- pkt_count update:
  - +1 when a written flit has ctrl_in=11.
  - -1 when a popped flit has ctrl_out=11.
  - Both in the same cycle: unchanged.
- Packet drain: once a head flit is offered, v_flit_out stays 1 through the tail, because that packet's tail is already buffered and counted.
- Single-flit packets are written with ctrl=11 only.
- ctrl_in=00 is stored as-is; it is never counted as a tail.
- Invariants, checked by assertions:
  - pkt_count <= fifo_count <= DEPTH.
  - fifo_count == wr_ptr - rd_ptr mod DEPTH, except when full.
  - No pop when pkt_count=0.

Test Plan:
1. Reset then idle -> out_req_fifo_rdy=1, v_flit_out=0, fifo_count=0, pkt_count=0, flit_out=0000.
2. Write 6-flit packet: head 0x1234 (01), 4 bodies 0x0001..0x0004 (10), tail 0x00FF (11), flit_ack_in=0.
   - v_flit_out stays 0 until the cycle after the tail write, then head 0x1234/01 is offered.
   - fifo_count=6, pkt_count=1.
3. Hold flit_ack_in=1 after scenario 2 -> six consecutive pops in order, ending with 0x00FF/11; next cycle v_flit_out=0, fifo_count=0, pkt_count=0.
4. Fill with 16 flits, no ack -> out_req_fifo_rdy=0 at fifo_count=16.
   - A 17th write sets err_overflow=1 and leaves fifo_count=16.
   - One ack then frees an entry: rdy=1 the next cycle.
5. Concurrent write of tail and pop of a different tail, at fifo_count=5, pkt_count=2 -> fifo_count=5, pkt_count=2 next cycle; pointers wrap correctly across entry 15->0.
6. Assert rst mid-drain (after 2 of 6 flits popped) -> immediately v_flit_out=0, rdy=1, counts 0, err_overflow=0. A subsequent new packet drains correctly.
